// File: rtl/axi_burst_master.sv
// Single-outstanding AXI burst master: one write (AW/W/B) or read (AR/R) burst per
// accepted command, reporting a one-cycle completion status with protocol checks.
module axi_burst_master #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned LEN_WIDTH      = 8,
  parameter int unsigned SIZE_WIDTH     = 3,
  parameter int unsigned BURST_WIDTH    = 2,
  parameter int unsigned RESP_WIDTH     = 2,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned STROBE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    axi_ACLK,
  input  logic                    axi_ARESET,
  // command port
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [SIZE_WIDTH-1:0]   cmd_size,
  input  logic [BURST_WIDTH-1:0]  cmd_burst,
  // write-data stream
  input  logic                    wd_valid,
  output logic                    wd_ready,
  input  logic [DATA_WIDTH-1:0]   wd_data,
  input  logic [STROBE_WIDTH-1:0] wd_strb,
  // read-data stream
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  // completion status
  output logic                    done_valid,
  output logic                    done_write,
  output logic [ID_WIDTH-1:0]     done_id,
  output logic [RESP_WIDTH-1:0]   done_resp,
  output logic [2:0]              done_err,
  // AXI write address
  output logic                    axi_AWVALID,
  input  logic                    axi_AWREADY,
  output logic [ID_WIDTH-1:0]     axi_AWID,
  output logic [ADDR_WIDTH-1:0]   axi_AWADDR,
  output logic [LEN_WIDTH-1:0]    axi_AWLEN,
  output logic [SIZE_WIDTH-1:0]   axi_AWSIZE,
  output logic [BURST_WIDTH-1:0]  axi_AWBURST,
  // AXI write data
  output logic                    axi_WVALID,
  input  logic                    axi_WREADY,
  output logic [DATA_WIDTH-1:0]   axi_WDATA,
  output logic [STROBE_WIDTH-1:0] axi_WSTRB,
  output logic                    axi_WLAST,
  // AXI write response
  input  logic                    axi_BVALID,
  output logic                    axi_BREADY,
  input  logic [ID_WIDTH-1:0]     axi_BID,
  input  logic [RESP_WIDTH-1:0]   axi_BRESP,
  // AXI read address
  output logic                    axi_ARVALID,
  input  logic                    axi_ARREADY,
  output logic [ID_WIDTH-1:0]     axi_ARID,
  output logic [ADDR_WIDTH-1:0]   axi_ARADDR,
  output logic [LEN_WIDTH-1:0]    axi_ARLEN,
  output logic [SIZE_WIDTH-1:0]   axi_ARSIZE,
  output logic [BURST_WIDTH-1:0]  axi_ARBURST,
  // AXI read data
  input  logic                    axi_RVALID,
  output logic                    axi_RREADY,
  input  logic [ID_WIDTH-1:0]     axi_RID,
  input  logic [DATA_WIDTH-1:0]   axi_RDATA,
  input  logic [RESP_WIDTH-1:0]   axi_RRESP,
  input  logic                    axi_RLAST
);

  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_RESP    = 3'd1;
  localparam logic [2:0] ERR_ID      = 3'd2;
  localparam logic [2:0] ERR_RLAST   = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_ILLEGAL = 3'd5;

  typedef enum logic [2:0] {
    IDLE, W_ADDR, W_DATA, W_RESP, R_ADDR, R_DATA, DONE
  } state_e;

  state_e                 state_q;
  logic                   cmd_ready_q;
  logic                   awvalid_q;
  logic                   arvalid_q;
  logic                   bready_q;
  logic                   done_valid_q;
  logic [2:0]             done_err_q;
  logic [RESP_WIDTH-1:0]  done_resp_q;

  logic                   write_q;
  logic [ID_WIDTH-1:0]    id_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [SIZE_WIDTH-1:0]  size_q;
  logic [BURST_WIDTH-1:0] burst_q;

  logic [LEN_WIDTH-1:0]   beat_q;
  logic [STALL_W-1:0]     stall_q;
  logic                   id_err_q;
  logic [RESP_WIDTH-1:0]  rresp_max_q;

  logic                   illegal_c;
  logic                   last_beat_c;
  logic                   stall_max_c;
  logic                   w_hs_c;
  logic                   r_hs_c;
  logic                   b_hs_c;
  logic                   id_err_d;
  logic [RESP_WIDTH-1:0]  rresp_max_d;
  logic [2:0]             rd_err_c;
  logic [2:0]             b_err_c;

  // Handshake detection, legality and error classification with priority 3 > 2 > 1.
  always_comb begin
    illegal_c   = (cmd_len == '0) || ((32'd1 << cmd_size) > 32'(STROBE_WIDTH));
    last_beat_c = (beat_q == (len_q - LEN_WIDTH'(1)));
    stall_max_c = (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));
    w_hs_c      = (state_q == W_DATA) && wd_valid && axi_WREADY;
    r_hs_c      = (state_q == R_DATA) && axi_RVALID && rd_ready;
    b_hs_c      = (state_q == W_RESP) && axi_BVALID && bready_q;
    id_err_d    = id_err_q || (axi_RID != id_q);
    rresp_max_d = (axi_RRESP > rresp_max_q) ? axi_RRESP : rresp_max_q;

    if (axi_RLAST != last_beat_c) begin
      rd_err_c = ERR_RLAST;
    end else if (id_err_d) begin
      rd_err_c = ERR_ID;
    end else if (rresp_max_d != '0) begin
      rd_err_c = ERR_RESP;
    end else begin
      rd_err_c = ERR_OK;
    end

    if (axi_BID != id_q) begin
      b_err_c = ERR_ID;
    end else if (axi_BRESP != '0) begin
      b_err_c = ERR_RESP;
    end else begin
      b_err_c = ERR_OK;
    end
  end

  // Address channels are driven straight from the latched command registers.
  assign cmd_ready   = cmd_ready_q;
  assign axi_AWVALID = awvalid_q;
  assign axi_AWID    = id_q;
  assign axi_AWADDR  = addr_q;
  assign axi_AWLEN   = len_q;
  assign axi_AWSIZE  = size_q;
  assign axi_AWBURST = burst_q;
  assign axi_ARVALID = arvalid_q;
  assign axi_ARID    = id_q;
  assign axi_ARADDR  = addr_q;
  assign axi_ARLEN   = len_q;
  assign axi_ARSIZE  = size_q;
  assign axi_ARBURST = burst_q;
  assign axi_BREADY  = bready_q;

  // Data streams pass through only while the matching data state is active.
  assign axi_WVALID  = (state_q == W_DATA) && wd_valid;
  assign axi_WDATA   = (state_q == W_DATA) ? wd_data : '0;
  assign axi_WSTRB   = (state_q == W_DATA) ? wd_strb : '0;
  assign axi_WLAST   = (state_q == W_DATA) && last_beat_c;
  assign wd_ready    = (state_q == W_DATA) && axi_WREADY;
  assign axi_RREADY  = (state_q == R_DATA) && rd_ready;
  assign rd_valid    = (state_q == R_DATA) && axi_RVALID;
  assign rd_data     = (state_q == R_DATA) ? axi_RDATA : '0;
  assign rd_last     = (state_q == R_DATA) && last_beat_c;

  assign done_valid  = done_valid_q;
  assign done_write  = write_q;
  assign done_id     = id_q;
  assign done_resp   = done_resp_q;
  assign done_err    = done_err_q;

  // Command FSM with registered valids/readies and completion status.
  always_ff @(posedge axi_ACLK) begin
    if (axi_ARESET) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b1;
      awvalid_q    <= 1'b0;
      arvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      done_valid_q <= 1'b0;
      done_err_q   <= '0;
      done_resp_q  <= '0;
      write_q      <= 1'b0;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      beat_q       <= '0;
      stall_q      <= '0;
      id_err_q     <= 1'b0;
      rresp_max_q  <= '0;
    end else begin
      done_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready_q <= 1'b0;
            write_q     <= cmd_write;
            id_q        <= cmd_id;
            addr_q      <= cmd_addr;
            len_q       <= cmd_len;
            size_q      <= cmd_size;
            burst_q     <= cmd_burst;
            beat_q      <= '0;
            stall_q     <= '0;
            id_err_q    <= 1'b0;
            rresp_max_q <= '0;
            if (illegal_c) begin
              state_q      <= DONE;
              done_valid_q <= 1'b1;
              done_err_q   <= ERR_ILLEGAL;
              done_resp_q  <= '0;
            end else if (cmd_write) begin
              state_q   <= W_ADDR;
              awvalid_q <= 1'b1;
            end else begin
              state_q   <= R_ADDR;
              arvalid_q <= 1'b1;
            end
          end
        end

        W_ADDR: begin
          if (axi_AWREADY) begin
            awvalid_q <= 1'b0;
            stall_q   <= '0;
            state_q   <= W_DATA;
          end else if (stall_max_c) begin
            awvalid_q    <= 1'b0;
            state_q      <= DONE;
            done_valid_q <= 1'b1;
            done_err_q   <= ERR_TIMEOUT;
            done_resp_q  <= rresp_max_q;
          end else begin
            stall_q <= stall_q + STALL_W'(1);
          end
        end

        W_DATA: begin
          if (w_hs_c) begin
            stall_q <= '0;
            if (last_beat_c) begin
              beat_q   <= '0;
              bready_q <= 1'b1;
              state_q  <= W_RESP;
            end else begin
              beat_q <= beat_q + LEN_WIDTH'(1);
            end
          end else if (stall_max_c) begin
            state_q      <= DONE;
            done_valid_q <= 1'b1;
            done_err_q   <= ERR_TIMEOUT;
            done_resp_q  <= rresp_max_q;
          end else begin
            stall_q <= stall_q + STALL_W'(1);
          end
        end

        W_RESP: begin
          if (b_hs_c) begin
            bready_q     <= 1'b0;
            state_q      <= DONE;
            done_valid_q <= 1'b1;
            done_err_q   <= b_err_c;
            done_resp_q  <= axi_BRESP;
          end else if (stall_max_c) begin
            bready_q     <= 1'b0;
            state_q      <= DONE;
            done_valid_q <= 1'b1;
            done_err_q   <= ERR_TIMEOUT;
            done_resp_q  <= rresp_max_q;
          end else begin
            stall_q <= stall_q + STALL_W'(1);
          end
        end

        R_ADDR: begin
          if (axi_ARREADY) begin
            arvalid_q <= 1'b0;
            stall_q   <= '0;
            state_q   <= R_DATA;
          end else if (stall_max_c) begin
            arvalid_q    <= 1'b0;
            state_q      <= DONE;
            done_valid_q <= 1'b1;
            done_err_q   <= ERR_TIMEOUT;
            done_resp_q  <= rresp_max_q;
          end else begin
            stall_q <= stall_q + STALL_W'(1);
          end
        end

        // An early RLAST ends the burst on the beat it arrives.
        R_DATA: begin
          if (r_hs_c) begin
            stall_q     <= '0;
            beat_q      <= beat_q + LEN_WIDTH'(1);
            id_err_q    <= id_err_d;
            rresp_max_q <= rresp_max_d;
            if (axi_RLAST || last_beat_c) begin
              state_q      <= DONE;
              done_valid_q <= 1'b1;
              done_err_q   <= rd_err_c;
              done_resp_q  <= rresp_max_d;
            end
          end else if (stall_max_c) begin
            state_q      <= DONE;
            done_valid_q <= 1'b1;
            done_err_q   <= ERR_TIMEOUT;
            done_resp_q  <= rresp_max_q;
          end else begin
            stall_q <= stall_q + STALL_W'(1);
          end
        end

        DONE: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end

        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

Single-outstanding AXI master command engine that sits directly upstream of the AXI memory slave in the verification and bring-up fabric. It accepts one burst command at a time on a simple valid/ready command port and drives the AW/W/B or AR/R channels. Write data comes from a streaming input and read data leaves on a streaming output. The block reports a one-cycle completion status with response, ID and protocol-check errors.

## Interface
- ADDR_WIDTH, 16, address width
- DATA_WIDTH, 32, data width
- LEN_WIDTH, 8, burst length field width
- SIZE_WIDTH, 3, burst size field width
- BURST_WIDTH, 2, burst type field width
- RESP_WIDTH, 2, response field width
- ID_WIDTH, 4, transaction ID width
- STROBE_WIDTH, DATA_WIDTH/8, write strobe width
- TIMEOUT_CYCLES, 1024, maximum stall cycles per handshake
---
- axi_ACLK  in  1  sole clock; all logic on the rising edge
- axi_ARESET  in  1  reset, synchronous, active-high
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_id  in  ID_WIDTH  transaction ID
- cmd_addr  in  ADDR_WIDTH  start byte address
- cmd_len  in  LEN_WIDTH  beat count (1..255)
- cmd_size  in  SIZE_WIDTH  bytes per beat = 2^size
- cmd_burst  in  BURST_WIDTH  burst type
- wd_valid / wd_ready  in/out  1  write-data stream handshake
- wd_data  in  DATA_WIDTH  write data
- wd_strb  in  STROBE_WIDTH  write byte strobes
- rd_valid / rd_ready  out/in  1  read-data stream handshake
- rd_data  out  DATA_WIDTH  read data
- rd_last  out  1  last read beat
- done_valid  out  1  one-cycle completion pulse
- done_write  out  1  completed command was a write
- done_id  out  ID_WIDTH  completed command ID
- done_resp  out  RESP_WIDTH  BRESP, or worst RRESP seen
- done_err  out  3  0 ok, 1 resp≠OKAY, 2 ID mismatch, 3 RLAST mismatch, 4 timeout, 5 illegal command
- Full AXI master ports: axi_AW{VALID,ID,ADDR,LEN,SIZE,BURST} out, axi_AWREADY in; axi_W{VALID,DATA,STRB,LAST} out, axi_WREADY in; axi_B{VALID,ID,RESP} in, axi_BREADY out; axi_AR{VALID,ID,ADDR,LEN,SIZE,BURST} out, axi_ARREADY in; axi_R{VALID,ID,DATA,RESP,LAST} in, axi_RREADY out. Widths come from the parameters.

## Operation
- FSM states: IDLE, W_ADDR, W_DATA, W_RESP, R_ADDR, R_DATA, DONE.
- cmd_ready is 1 only in IDLE. On accept, all command fields are latched.
- Illegal command (cmd_len==0, or 2^cmd_size > STROBE_WIDTH): go to DONE with err 5; no AXI activity.
- AxLEN is driven with the beat count itself, not beats−1. This is the fabric-wide convention the slave consumes.
- W_ADDR / R_ADDR: AWVALID or ARVALID is registered high with the latched fields until the READY handshake.
  - After the AW handshake, go to W_DATA.
  - After the AR handshake, go to R_DATA.
- W_DATA: WVALID = wd_valid, WDATA/WSTRB = wd_data/wd_strb, wd_ready = axi_WREADY. All are combinational pass-through, gated by state.
  - An 8-bit beat counter increments on each W handshake.
  - WLAST = (beat == len−1).
  - After the last handshake, go to W_RESP.
- W_RESP: BREADY=1. On a B handshake, capture BRESP.
  - err 2 if BID ≠ latched ID.
  - Otherwise err 1 if BRESP ≠ 0.
  - Then go to DONE.
- R_DATA: RREADY = rd_ready, rd_valid = RVALID, rd_data = RDATA, rd_last = (beat == len−1).
  - On each handshake: check RID (err 2); track max RRESP (err 1).
  - RLAST asserted before the final beat → err 3; finish immediately.
  - RLAST missing on the final beat → err 3.
  - After the final beat, go to DONE.
- Error priority, highest first: 4, 3, 2, 1.
- DONE: done_valid=1 for exactly one cycle with status; next cycle go to IDLE.
- Timeout: a 10-bit+ stall counter clears on state entry and on any handshake of the current channel.
  - Reaching TIMEOUT_CYCLES−1 deasserts all master valids/readies and goes to DONE with err 4.
  - This is a debug-only protocol break.

## Timing
- Reset values: every output 0, except cmd_ready=1 (IDLE). FSM IDLE, counters 0.
- Reset mid-burst: on the next edge all valids/readies are 0, no done pulse is issued, and the FSM is IDLE.
- Command accepted at edge N → AWVALID/ARVALID high from N+1.
- AW handshake at edge M → W_DATA from M+1; W never precedes the AW handshake.
- Minimum write: len beats + 3 cycles from command to done_valid, with zero-wait slave and source.
- Minimum read: len + 2 cycles from command to done_valid, with zero-wait slave and source.
- After done_valid at cycle D, cmd_ready is high at D+1.

## Test plan
- Write addr 0x0010, len 4, size 2, INCR (01), data 0xA0..0xA3, strb 0xF → AWLEN=4, WLAST on 4th beat only, BRESP 0, done_err 0, done_id = cmd_id.
- Read back 0x0010, len 4 → rd_data 0xA0..0xA3, rd_last on 4th beat, done_err 0.
- Write len 3 with a 2-cycle wd_valid gap before beat 2 → WVALID low during the gap, beat count intact, WLAST on 3rd beat.
- Slave returns RID=5 for cmd_id=3 → done_err 2; RLAST on beat 2 of len 4 → done_err 3.
- AWREADY held low 1024 cycles → AWVALID drops, done_err 4; cmd_len=0 → done_err 5 with no AWVALID.
- axi_ARESET pulsed during beat 2 of a write → next cycle all valids 0, cmd_ready 1, no done_valid.
